mips_multicycle_ctrl: RTL and testbench

- Moore FSM that sequences the shared-memory multicycle MIPS datapath: single memory port for instruction and data, one ALU reused for PC increment, address calc and execute.
- Decodes op each instruction and drives all datapath enables and muxes.
- Supported instructions: LW, SW, R-type, BEQ, J, ADDI.
- Stretches memory states on a ready handshake and aborts on memory timeout.

---
 rtl/mips_ctrl_pkg.sv | 73 +++++++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, datapath mux
// selects, FSM state numbering and the decoded control-word payload.
package mips_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADDI  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsource_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    // Control word driven onto the datapath each cycle.
    typedef struct packed {
        logic      pc_en;
        logic      iord;
        logic      memread;
        logic      memwrite;
        logic      irwrite;
        logic      memtoreg;
        logic      regdst;
        logic      regwrite;
        logic      alusrca;
        alusrcb_e  alusrcb;
        aluop_e    aluop;
        pcsource_e pcsource;
    } ctrl_s;

    // States that own the memory port and may be stretched by mem_ready.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stall cycles of a memory state and flags the cycle in which the
// wait budget is exhausted while the access is still outstanding.
module mem_wait_timer
    import mips_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             count_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating stall counter; clear wins over count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = count_i && (cnt_q >= timeout_i);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle MIPS datapath.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_op).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned STATE_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsource,
    output logic               mem_err,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    state_e state_q;
    state_e state_d;
    ctrl_s  ctrl;
    logic   wait_cnt_en;
    logic   wait_clr;
    logic   expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory states hold until mem_ready or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expired) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWR: begin
                if (mem_ready || expired) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word decoded from the state register.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pc_en   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
                ctrl.pc_en    = zero;
            end
            S_JUMP: begin
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.pc_en    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADDI;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter restarts on every state entry, including a FETCH retry.
    assign wait_cnt_en = is_mem_state(state_q) && !mem_ready;
    assign wait_clr    = (state_d != state_q) || expired;

    mem_wait_timer u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wait_clr),
        .count_i   (wait_cnt_en),
        .timeout_i (CNT_W'(TIMEOUT_CYCLES)),
        .expired_c (expired)
    );

    // Write strobes are suppressed while reset is applied.
    assign pc_en     = ctrl.pc_en    & ~reset;
    assign irwrite   = ctrl.irwrite  & ~reset;
    assign regwrite  = ctrl.regwrite & ~reset;
    assign memwrite  = ctrl.memwrite & ~reset;
    assign iord      = ctrl.iord;
    assign memread   = ctrl.memread;
    assign memtoreg  = ctrl.memtoreg;
    assign regdst    = ctrl.regdst;
    assign alusrca   = ctrl.alusrca;
    assign alusrcb   = ctrl.alusrcb;
    assign aluop     = ctrl.aluop;
    assign pcsource  = ctrl.pcsource;
    assign mem_err   = expired & ~reset;
    assign state_dbg = STATE_W'(state_q);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: instructions expand into per-cycle expectations that are
// checked against the controller every cycle, plus literal latency/tally checks.
module tb_mips_multicycle_ctrl;

    localparam int T = 4;
    localparam int STUCK = 255;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;
    // pc_en, memwrite, irwrite, regwrite, mem_err bit positions
    localparam logic [15:0] STROBES = 16'h9901;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       mem_err;
    logic [3:0] state_dbg;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(T), .STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_en     (pc_en),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsource  (pcsource),
        .mem_err   (mem_err),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [5:0]  op;
        bit          z;
        bit          rdy;
        int          st;
        bit          chk_st;
        logic [15:0] outs;
        logic [15:0] mask;
        bit          ill;
        int          tag;
    } cyc_t;

    cyc_t q[$];
    int   cur_tag;
    int   checks;
    int   errors;
    int   mw_cnt[16];
    int   rw_cnt[16];
    int   err_cnt[16];
    int   pcen_cnt[16];

    // Output vector each state must present, straight from the state table.
    function automatic logic [15:0] spec_outs(int st, bit rdy, bit z, bit err);
        logic e_pc, e_iord, e_mrd, e_mwr, e_ir, e_m2r, e_dst, e_rw, e_sa;
        logic [1:0] e_sb, e_op, e_ps;
        {e_pc, e_iord, e_mrd, e_mwr, e_ir, e_m2r, e_dst, e_rw, e_sa} = '0;
        e_sb = 2'b00; e_op = 2'b00; e_ps = 2'b00;
        case (st)
            0:  begin e_mrd = 1; e_sb = 2'b01; e_ir = rdy; e_pc = rdy; end
            1:  e_sb = 2'b11;
            2:  begin e_sa = 1; e_sb = 2'b10; end
            3:  begin e_iord = 1; e_mrd = 1; end
            4:  begin e_rw = 1; e_m2r = 1; end
            5:  begin e_iord = 1; e_mwr = 1; end
            6:  begin e_sa = 1; e_op = 2'b10; end
            7:  begin e_rw = 1; e_dst = 1; end
            8:  begin e_sa = 1; e_op = 2'b01; e_ps = 2'b01; e_pc = z; end
            9:  begin e_ps = 2'b10; e_pc = 1; end
            10: begin e_sa = 1; e_sb = 2'b10; e_op = 2'b11; end
            11: e_rw = 1;
            default: ;
        endcase
        return {e_pc, e_iord, e_mrd, e_mwr, e_ir, e_m2r, e_dst, e_rw, e_sa, e_sb, e_op, e_ps, err};
    endfunction

    task automatic push(bit rst, logic [5:0] op_v, bit z, bit rdy, int st, bit err, bit ill);
        cyc_t r;
        r.rst = rst; r.op = op_v; r.z = z; r.rdy = rdy; r.st = st; r.chk_st = 1'b1;
        r.outs = rst ? 16'h0000 : spec_outs(st, rdy, z, err);
        r.mask = rst ? STROBES : 16'hFFFF;
        r.ill = ill; r.tag = cur_tag;
        q.push_back(r);
    endtask

    task automatic step(logic [5:0] op_v, bit z, bit rdy, int st);
        push(1'b0, op_v, z, rdy, st, 1'b0, 1'b0);
    endtask

    // A memory state with w stall cycles; w above the budget times out.
    task automatic mem_phase(int st, logic [5:0] op_v, bit z, int w, output bit ok);
        int n;
        n = (w > T) ? T : w;
        for (int i = 0; i < n; i++) step(op_v, z, 1'b0, st);
        if (w > T) begin
            push(1'b0, op_v, z, 1'b0, st, 1'b1, 1'b0);
            ok = 1'b0;
        end else begin
            step(op_v, z, 1'b1, st);
            ok = 1'b1;
        end
    endtask

    task automatic add_instr(logic [5:0] op_v, bit z, int fw, int mw);
        bit ok;
        mem_phase(0, op_v, z, fw, ok);
        if (!ok) return;
        step(op_v, z, 1'b0, 1);
        case (op_v)
            LW:   begin step(op_v, z, 1'b0, 2); mem_phase(3, op_v, z, mw, ok); if (ok) step(op_v, z, 1'b0, 4); end
            SW:   begin step(op_v, z, 1'b0, 2); mem_phase(5, op_v, z, mw, ok); end
            RT:   begin step(op_v, z, 1'b0, 6); step(op_v, z, 1'b0, 7); end
            BEQ:  step(op_v, z, 1'b0, 8);
            JMP:  step(op_v, z, 1'b0, 9);
            ADDI: begin step(op_v, z, 1'b0, 10); step(op_v, z, 1'b0, 11); end
            default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) push(1'b0, op_v, z, 1'b1, 12, 1'b0, 1'b1);
                push(1'b1, op_v, z, 1'b1, 12, 1'b0, 1'b0);
`endif
            end
        endcase
    endtask

    task automatic check_lit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic add_len(string name, logic [5:0] op_v, bit z, int fw, int mw, int want);
        int n0;
        n0 = q.size();
        add_instr(op_v, z, fw, mw);
        check_lit(name, q.size() - n0, want);
    endtask

    initial begin
        logic [15:0] got;
        bit bad;
        checks = 0; errors = 0;
        reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin mw_cnt[i] = 0; rw_cnt[i] = 0; err_cnt[i] = 0; pcen_cnt[i] = 0; end

        cur_tag = 0;
        push(1'b1, RT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        push(1'b1, RT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cur_tag = 1;  add_len("lw_len", LW, 1'b1, 0, 0, 5);
        cur_tag = 2;  add_len("sw_wait3_len", SW, 1'b1, 0, 3, 7);
        cur_tag = 3;  add_len("beq_taken_len", BEQ, 1'b1, 0, 0, 3);
        cur_tag = 4;  add_len("beq_not_len", BEQ, 1'b0, 0, 0, 3);
        cur_tag = 5;  add_len("addi_len", ADDI, 1'b1, 1, 0, 5);
        cur_tag = 6;  add_len("rtype_len", RT, 1'b1, 2, 0, 6);
        cur_tag = 7;  add_len("j_len", JMP, 1'b0, 0, 0, 3);
        cur_tag = 8;  add_len("lw_timeout_len", LW, 1'b0, 0, STUCK, 8);
        cur_tag = 9;  add_len("lw_edge_len", LW, 1'b0, 0, T, 9);
        cur_tag = 10; add_len("fetch_timeout_len", JMP, 1'b0, STUCK, 0, 5);
        add_len("fetch_retry_len", JMP, 1'b0, 0, 0, 3);
        cur_tag = 11;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        add_len("illegal_len", BAD, 1'b0, 0, 0, 6);
`else
        add_len("illegal_len", BAD, 1'b0, 0, 0, 2);
`endif
        cur_tag = 12;
        step(SW, 1'b0, 1'b1, 0); step(SW, 1'b0, 1'b0, 1); step(SW, 1'b0, 1'b0, 2);
        step(SW, 1'b0, 1'b0, 5);
        push(1'b1, SW, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        cur_tag = 13; add_len("lw_after_rst_len", LW, 1'b1, 0, 0, 5);
        cur_tag = 14; add_len("sw_wait1_len", SW, 1'b0, 0, 1, 5);

        foreach (q[i]) begin
            @(negedge clk);
            reset = q[i].rst; op = q[i].op; zero = q[i].z; mem_ready = q[i].rdy;
            #1;
            got = {pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
                   alusrca, alusrcb, aluop, pcsource, mem_err};
            bad = (((got ^ q[i].outs) & q[i].mask) != 16'h0) ||
                  (q[i].chk_st && (state_dbg != 4'(q[i].st)));
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            if (!q[i].rst && (illegal_op != q[i].ill)) bad = 1'b1;
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cycle %0d tag %0d: got state %0d outs %h, want state %0d outs %h mask %h",
                         i, q[i].tag, state_dbg, got, q[i].st, q[i].outs, q[i].mask);
            end
            if (memwrite) mw_cnt[q[i].tag]++;
            if (regwrite) rw_cnt[q[i].tag]++;
            if (mem_err)  err_cnt[q[i].tag]++;
            if (pc_en)    pcen_cnt[q[i].tag]++;
        end

        check_lit("lw_regwrite_cnt", rw_cnt[1], 1);
        check_lit("sw_memwrite_cnt", mw_cnt[2], 4);
        check_lit("sw_regwrite_cnt", rw_cnt[2], 0);
        check_lit("beq_taken_pcen", pcen_cnt[3], 2);
        check_lit("beq_not_pcen", pcen_cnt[4], 1);
        check_lit("lw_timeout_err", err_cnt[8], 1);
        check_lit("lw_timeout_regwrite", rw_cnt[8], 0);
        check_lit("lw_edge_err", err_cnt[9], 0);
        check_lit("lw_edge_regwrite", rw_cnt[9], 1);
        check_lit("fetch_timeout_err", err_cnt[10], 1);
        check_lit("rst_memwr_memwrite", mw_cnt[12], 1);
        check_lit("lw_after_rst_err", err_cnt[13], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
